// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative multiply/divide unit holding the architectural HI/LO
// registers. It executes MULT, MULTU, DIV, DIVU, MTHI and MTLO.
// Multiply uses shift-add, one multiplier bit per cycle. Divide uses restoring
// division, one quotient bit per cycle. Both run on operand magnitudes, and the
// signs are applied in FIX.
//
// Optional build macro: MULDIV_CANCEL_EN adds a cancel input that aborts the
// operation in flight (pipeline flush).
//
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   start  one-cycle operation request (ignored while busy)
//   op     000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO, else no-op
//   a      rs operand (multiplicand, dividend, MTHI/MTLO data)
//   b      rt operand (multiplier, divisor)
//   cancel (MULDIV_CANCEL_EN only) abort the operation in flight
//   busy   operation in progress
//   done   one-cycle pulse when HI/LO have been updated
//   hi     HI register
//   lo     LO register
module muldiv_unit #(
   parameter int unsigned WIDTH = 32,
   parameter int unsigned CNT_W = 6
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [2:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
`ifdef MULDIV_CANCEL_EN
   input  logic             cancel,
`endif
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);

   typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

   localparam logic [2:0] OP_MTHI = 3'b100;
   localparam logic [2:0] OP_MTLO = 3'b101;

   state_t             state, state_d;
   logic [CNT_W-1:0]   cnt, cnt_d;
   logic [2*WIDTH-1:0] acc, acc_d;     // mult: {upper, multiplier/lower}; div: {rem, quot}
   logic [WIDTH-1:0]   opnd, opnd_d;   // multiplicand or divisor magnitude
   logic               is_div, is_div_d;
   logic               neg_lo, neg_lo_d; // negate product (mult) or quotient (div)
   logic               neg_hi, neg_hi_d; // negate remainder (signed div only)
   logic               busy_d, done_d;
   logic [WIDTH-1:0]   hi_d, lo_d;

   logic               sgn, sa, sb;
   logic [WIDTH-1:0]   mag_a, mag_b;
   logic [WIDTH:0]     add_sum, rem_sh, sub_diff;
   logic [2*WIDTH-1:0] prod;
   logic               kill;

`ifdef MULDIV_CANCEL_EN
   assign kill = cancel;
`else
   assign kill = 1'b0;
`endif

   // State and datapath registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state  <= IDLE;
         cnt    <= '0;
         acc    <= '0;
         opnd   <= '0;
         is_div <= 1'b0;
         neg_lo <= 1'b0;
         neg_hi <= 1'b0;
         busy   <= 1'b0;
         done   <= 1'b0;
         hi     <= '0;
         lo     <= '0;
      end else begin
         state  <= state_d;
         cnt    <= cnt_d;
         acc    <= acc_d;
         opnd   <= opnd_d;
         is_div <= is_div_d;
         neg_lo <= neg_lo_d;
         neg_hi <= neg_hi_d;
         busy   <= busy_d;
         done   <= done_d;
         hi     <= hi_d;
         lo     <= lo_d;
      end
   end

   // Next-state and datapath logic
   always_comb begin
      state_d  = state;
      cnt_d    = cnt;
      acc_d    = acc;
      opnd_d   = opnd;
      is_div_d = is_div;
      neg_lo_d = neg_lo;
      neg_hi_d = neg_hi;
      busy_d   = busy;
      done_d   = 1'b0;
      hi_d     = hi;
      lo_d     = lo;
      sgn      = ~op[0];
      sa       = sgn & a[WIDTH-1];
      sb       = sgn & b[WIDTH-1];
      mag_a    = sa ? -a : a;
      mag_b    = sb ? -b : b;
      add_sum  = '0;
      rem_sh   = '0;
      sub_diff = '0;
      prod     = neg_lo ? -acc : acc;

      unique case (state)
         IDLE: begin
            if (start && !kill) begin
               if (!op[2]) begin
                  is_div_d = op[1];
                  cnt_d    = '0;
                  busy_d   = 1'b1;
                  if (op[1] && (b == '0)) begin
                     // Divide by zero: raw dividend to HI, all ones to LO
                     acc_d    = {a, {WIDTH{1'b1}}};
                     neg_lo_d = 1'b0;
                     neg_hi_d = 1'b0;
                     state_d  = FIX;
                  end else if (op[1]) begin
                     acc_d    = {{WIDTH{1'b0}}, mag_a};
                     opnd_d   = mag_b;
                     neg_lo_d = sa ^ sb;
                     neg_hi_d = sa;
                     state_d  = RUN;
                  end else begin
                     acc_d    = {{WIDTH{1'b0}}, mag_b};
                     opnd_d   = mag_a;
                     neg_lo_d = sa ^ sb;
                     neg_hi_d = 1'b0;
                     state_d  = RUN;
                  end
               end else if (op == OP_MTHI) begin
                  hi_d   = a;
                  done_d = 1'b1;
               end else if (op == OP_MTLO) begin
                  lo_d   = a;
                  done_d = 1'b1;
               end
            end
         end
         RUN: begin
            if (!is_div) begin
               // Add multiplicand into upper half if current multiplier bit set, shift right
               add_sum = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, (acc[0] ? opnd : {WIDTH{1'b0}})};
               acc_d   = {add_sum, acc[WIDTH-1:1]};
            end else begin
               // Shift next dividend bit into remainder; keep difference if no borrow
               rem_sh   = acc[2*WIDTH-1:WIDTH-1];
               sub_diff = rem_sh - {1'b0, opnd};
               if (!sub_diff[WIDTH])
                  acc_d = {sub_diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
               else
                  acc_d = {rem_sh[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
            end
            cnt_d = cnt + CNT_W'(1);
            if (cnt == CNT_W'(WIDTH-1))
               state_d = FIX;
         end
         FIX: begin
            if (is_div) begin
               hi_d = neg_hi ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
               lo_d = neg_lo ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
            end else begin
               hi_d = prod[2*WIDTH-1:WIDTH];
               lo_d = prod[WIDTH-1:0];
            end
            done_d  = 1'b1;
            busy_d  = 1'b0;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase

      // Flush: abandon the operation without touching HI/LO
      if (kill && (state != IDLE)) begin
         state_d = IDLE;
         busy_d  = 1'b0;
         done_d  = 1'b0;
         hi_d    = hi;
         lo_d    = lo;
      end
   end

endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: directed self-checking bench for muldiv_unit.
module tb_muldiv_unit;

   localparam int unsigned W = 32;

   localparam logic [2:0] OP_MULT  = 3'b000;
   localparam logic [2:0] OP_MULTU = 3'b001;
   localparam logic [2:0] OP_DIV   = 3'b010;
   localparam logic [2:0] OP_DIVU  = 3'b011;
   localparam logic [2:0] OP_MTHI  = 3'b100;
   localparam logic [2:0] OP_MTLO  = 3'b101;

   logic         clk = 1'b0;
   logic         rst_n;
   logic         start;
   logic [2:0]   op;
   logic [W-1:0] a, b;
   logic         cancel;
   logic         busy, done;
   logic [W-1:0] hi, lo;

   int checks = 0;
   int failures = 0;
   int lat, busy_bad, pulses;

   muldiv_unit #(.WIDTH(W), .CNT_W(6)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .start (start),
      .op    (op),
      .a     (a),
      .b     (b),
`ifdef MULDIV_CANCEL_EN
      .cancel(cancel),
`endif
      .busy  (busy),
      .done  (done),
      .hi    (hi),
      .lo    (lo)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Present a request for one edge; returns #1 after the sampling edge
   task automatic issue(input logic [2:0] o, input logic [W-1:0] va, input logic [W-1:0] vb);
      @(negedge clk);
      start = 1'b1;
      op    = o;
      a     = va;
      b     = vb;
      @(posedge clk);
      #1;
      start = 1'b0;
   endtask

   // Waits for done; lat = edges after the start edge. Optionally injects a
   // MULTU 7*6 request at a given point while busy.
   task automatic wait_done(input int inject_at, output int l, output int bb);
      l  = 0;
      bb = 0;
      while (!done && l < 200) begin
         if (!busy) bb++;
         if (l == inject_at) begin
            start = 1'b1; op = OP_MULTU; a = 32'd7; b = 32'd6;
         end else begin
            start = 1'b0;
         end
         @(posedge clk);
         #1;
         l++;
      end
      start = 1'b0;
      check("done_seen", 64'(done), 64'd1);
   endtask

   initial begin
      rst_n = 1'b0; start = 1'b0; op = 3'b111; a = '0; b = '0; cancel = 1'b0;
      #12;
      check("rst_busy", 64'(busy), 64'd0);
      check("rst_done", 64'(done), 64'd0);
      check("rst_hi", 64'(hi), 64'd0);
      check("rst_lo", 64'(lo), 64'd0);
      @(negedge clk);
      rst_n = 1'b1;

      // MULTU max*max
      issue(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
      check("multu_busy_hold", 64'(busy), 64'd1);
      wait_done(-1, lat, busy_bad);
      check("multu_lat", 64'(lat), 64'd33);
      check("multu_busy_gap", 64'(busy_bad), 64'd0);
      check("multu_busy_end", 64'(busy), 64'd0);
      check("multu_hi", 64'(hi), 64'hFFFF_FFFE);
      check("multu_lo", 64'(lo), 64'h0000_0001);
      @(posedge clk); #1;
      check("multu_done_pulse", 64'(done), 64'd0);

      // MULT -3 * 5
      issue(OP_MULT, 32'hFFFF_FFFD, 32'd5);
      wait_done(-1, lat, busy_bad);
      check("mult_hi", 64'(hi), 64'hFFFF_FFFF);
      check("mult_lo", 64'(lo), 64'hFFFF_FFF1);

      // DIV -7 / 2
      issue(OP_DIV, 32'hFFFF_FFF9, 32'd2);
      wait_done(-1, lat, busy_bad);
      check("div_lat", 64'(lat), 64'd33);
      check("div_lo", 64'(lo), 64'hFFFF_FFFD);
      check("div_hi", 64'(hi), 64'hFFFF_FFFF);

      // DIVU by zero
      issue(OP_DIVU, 32'h1234_5678, 32'd0);
      wait_done(-1, lat, busy_bad);
      check("div0_lat", 64'(lat), 64'd1);
      check("div0_hi", 64'(hi), 64'h1234_5678);
      check("div0_lo", 64'(lo), 64'hFFFF_FFFF);

      // Signed overflow case
      issue(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
      wait_done(-1, lat, busy_bad);
      check("divovf_lo", 64'(lo), 64'h8000_0000);
      check("divovf_hi", 64'(hi), 64'd0);

      // MTHI / MTLO
      issue(OP_MTHI, 32'hDEAD_BEEF, 32'd0);
      check("mthi_hi", 64'(hi), 64'hDEAD_BEEF);
      check("mthi_done", 64'(done), 64'd1);
      check("mthi_busy", 64'(busy), 64'd0);
      issue(OP_MTLO, 32'hCAFE_F00D, 32'd0);
      check("mtlo_lo", 64'(lo), 64'hCAFE_F00D);
      check("mtlo_hi_keep", 64'(hi), 64'hDEAD_BEEF);
      check("mtlo_done", 64'(done), 64'd1);
      check("mtlo_busy", 64'(busy), 64'd0);
      @(posedge clk); #1;
      check("mtlo_done_pulse", 64'(done), 64'd0);

      // DIVU 100/7 with a MULTU injected while busy; old HI/LO visible during busy
      issue(OP_DIVU, 32'd100, 32'd7);
      check("busy_old_hi", 64'(hi), 64'hDEAD_BEEF);
      wait_done(4, lat, busy_bad);
      check("inject_lat", 64'(lat), 64'd33);
      check("inject_lo", 64'(lo), 64'd14);
      check("inject_hi", 64'(hi), 64'd2);
      @(posedge clk); #1;
      check("inject_no_restart", 64'(busy), 64'd0);

      // Reset mid-operation
      issue(OP_MULTU, 32'd3, 32'd4);
      repeat (9) @(posedge clk);
      #1;
      rst_n = 1'b0;
      #1;
      check("abort_busy", 64'(busy), 64'd0);
      check("abort_done", 64'(done), 64'd0);
      check("abort_hi", 64'(hi), 64'd0);
      check("abort_lo", 64'(lo), 64'd0);
      @(negedge clk);
      rst_n = 1'b1;
      issue(OP_MULTU, 32'd3, 32'd4);
      wait_done(-1, lat, busy_bad);
      check("post_rst_lo", 64'(lo), 64'd12);
      check("post_rst_hi", 64'(hi), 64'd0);

`ifdef MULDIV_CANCEL_EN
      issue(OP_MTHI, 32'h5555_5555, 32'd0);
      issue(OP_MTLO, 32'h5555_5555, 32'd0);
      issue(OP_MULTU, 32'd9, 32'd9);
      repeat (19) @(posedge clk);
      #1;
      cancel = 1'b1;
      @(posedge clk); #1;
      cancel = 1'b0;
      check("cancel_busy", 64'(busy), 64'd0);
      check("cancel_done", 64'(done), 64'd0);
      pulses = 0;
      repeat (40) begin
         @(posedge clk); #1;
         if (done) pulses++;
      end
      check("cancel_no_done", 64'(pulses), 64'd0);
      check("cancel_hi", 64'(hi), 64'h5555_5555);
      check("cancel_lo", 64'(lo), 64'h5555_5555);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
